// File: rtl/instr_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Fetch/execute/store sequencer between a CPU core and a
//               request/acknowledge memory port, with a memory-timeout fault.
// Revision    : 1.0 - initial release
// ============================================================================

module instr_sequencer #(
    parameter int WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [7:0]  cpu_address,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_store,
    output logic        cpu_en,
    output logic [7:0]  inst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        fault,
    output logic [15:0] instr_count
);

    localparam int c_wait_w = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_DECODE = 3'd3,
        S_STORE  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_cpu_en;
    logic [7:0]          r_inst;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [7:0]          r_mem_addr;
    logic [7:0]          r_mem_wdata;
    logic                r_busy;
    logic                r_fault;
    logic [15:0]         r_instr_count;
    logic [c_wait_w-1:0] r_wait;

    logic                w_timeout;

    // The final permitted wait cycle has passed without an acknowledge.
    assign w_timeout = !mem_ack && (r_wait == c_wait_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cpu_en      <= 1'b0;
            r_inst        <= 8'h00;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= 8'h00;
            r_mem_wdata   <= 8'h00;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
            r_instr_count <= 16'h0000;
            r_wait        <= '0;
        end else begin
            r_cpu_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        r_state    <= S_FETCH;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= cpu_address;
                        r_wait     <= '0;
                        r_busy     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_state       <= S_EXEC;
                        r_inst        <= mem_rdata;
                        r_mem_req     <= 1'b0;
                        r_cpu_en      <= 1'b1;
                        r_instr_count <= r_instr_count + 16'd1;
                    end else if (w_timeout) begin
                        r_state   <= S_HALT;
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_fault   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_EXEC: begin
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    if (cpu_store) begin
                        r_state     <= S_STORE;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= cpu_address;
                        r_mem_wdata <= cpu_data;
                        r_wait      <= '0;
                    end else if (run) begin
                        r_state    <= S_FETCH;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= cpu_address;
                        r_wait     <= '0;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_STORE: begin
                    if (mem_ack) begin
                        if (run) begin
                            // Back-to-back fetch: mem_req stays high across the boundary.
                            r_state    <= S_FETCH;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= cpu_address;
                            r_wait     <= '0;
                        end else begin
                            r_state   <= S_IDLE;
                            r_mem_req <= 1'b0;
                            r_busy    <= 1'b0;
                        end
                    end else if (w_timeout) begin
                        r_state   <= S_HALT;
                        r_mem_req <= 1'b0;
                        r_busy    <= 1'b0;
                        r_fault   <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_HALT: begin
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                    r_fault   <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_en      = r_cpu_en;
    assign inst        = r_inst;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign busy        = r_busy;
    assign fault       = r_fault;
    assign instr_count = r_instr_count;

endmodule

`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: WAIT_MAX, default 16, maximum number of cycles a memory request may stay pending without mem_ack before a fault.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 run  input  1  1 = fetch/execute enabled; 0 = stop at next instruction boundary.
REQ-005 cpu_address  input  8  next-instruction or store address from the CPU datapath.
REQ-006 cpu_data  input  8  store data from the CPU datapath.
REQ-007 cpu_store  input  1  store request from the CPU controller.
REQ-008 cpu_en  output  1  one-cycle advance strobe to the CPU (IR/PC/register-file enable).
REQ-009 inst  output  8  registered instruction presented to the CPU.
REQ-010 mem_req  output  1  memory request, held until acknowledged.
REQ-011 mem_we  output  1  1 = write (store), 0 = read (fetch).
REQ-012 mem_addr  output  8  memory address, registered.
REQ-013 mem_wdata  output  8  memory write data, registered.
REQ-014 mem_rdata  input  8  memory read data, valid in the cycle mem_ack=1.
REQ-015 mem_ack  input  1  memory completion, single-cycle pulse.
REQ-016 busy  output  1  1 in any state other than IDLE and HALT.
REQ-017 fault  output  1  sticky memory-timeout flag.
REQ-018 instr_count  output  16  number of cpu_en strobes since reset.

Function
REQ-019 FSM states: IDLE, FETCH, EXEC, DECODE, STORE, HALT.
REQ-020 IDLE: mem_req=0; run=1 -> FETCH, latching mem_addr=cpu_address, mem_we=0.
REQ-021 FETCH: mem_req=1; on mem_ack, inst<=mem_rdata, then -> EXEC.
REQ-022 EXEC: lasts exactly one cycle, cpu_en=1, instr_count increments (wraps 0xFFFF->0x0000), then -> DECODE.
REQ-023 DECODE: one cycle, cpu_en=0, cpu_store sampled. cpu_store=1 -> STORE, latching mem_addr=cpu_address, mem_wdata=cpu_data, mem_we=1. Else run=1 -> FETCH, latching mem_addr=cpu_address, mem_we=0. Else -> IDLE.
REQ-024 STORE: mem_req=1; on mem_ack, run=1 -> FETCH with the FETCH latching of REQ-023, else -> IDLE.
REQ-025 mem_ack is accepted in any cycle with mem_req=1, including the first; it is ignored when mem_req=0.
REQ-026 While mem_req=1, mem_addr, mem_we and mem_wdata stay constant.
REQ-027 Minimum fetch-to-fetch latency with no store: 3 cycles (FETCH with immediate ack, EXEC, DECODE).
REQ-028 run deasserted during FETCH/STORE: the pending transaction completes. An in-progress fetch still executes (EXEC, DECODE). The FSM then enters IDLE.
REQ-029 Wait counter: cleared on entry to FETCH/STORE; increments each FETCH/STORE cycle without mem_ack. A cycle with mem_ack=0 while the counter equals WAIT_MAX-1 -> HALT.
REQ-030 HALT: mem_req=0, cpu_en=0, fault=1; left only by reset; inst and instr_count hold.
REQ-031 cpu_en is never asserted outside EXEC; inst changes only on a FETCH acknowledge.

Reset
REQ-032 With reset=1 at a rising edge, regardless of state (including mid-transaction), the block SHALL enter IDLE. In the same edge: mem_req=0, mem_we=0, mem_addr=0x00, mem_wdata=0x00, inst=0x00, cpu_en=0, busy=0, fault=0, instr_count=0x0000, wait counter=0.
REQ-033 A mem_ack arriving in the cycle after reset SHALL be ignored.

Verification
REQ-034 run=1, cpu_address=0x10, mem_ack the first request cycle with rdata=0x5A -> mem_addr=0x10, mem_we=0; inst=0x5A; cpu_en high exactly one cycle; instr_count=1; next fetch 3 cycles after the first.
REQ-035 cpu_store=1 in DECODE, cpu_address=0x22, cpu_data=0xC3, ack after 4 cycles -> mem_we=1, addr 0x22, wdata 0xC3 stable all 4 cycles; then a FETCH follows.
REQ-036 WAIT_MAX=16, no ack in FETCH -> mem_req high exactly 16 cycles; then HALT, fault=1, busy=0; fault persists until reset.
REQ-037 run dropped on the 2nd cycle of a FETCH, ack on the 3rd -> EXEC and DECODE occur, then IDLE; no further mem_req.
REQ-038 reset asserted during a STORE wait -> next cycle all outputs at their REQ-032 values; an ack arriving one cycle later leaves inst and instr_count at 0.
REQ-039 Run 65536 instructions -> instr_count wraps to 0x0000.
